// File: rtl/decode_queue_pkg.sv
// Shared types and helpers for the decode instruction queue.
package decode_queue_pkg;

  localparam int unsigned IQ_PC_WIDTH = 32;
  localparam int unsigned PC_STEP     = 4;

  typedef struct packed {
    logic [31:0]            inst;
    logic [IQ_PC_WIDTH-1:0] pc;
  } iq_entry_t;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/enq_lane_compactor.sv
// Packs the set fetch lanes into consecutive slots (ascending lane order), each
// carrying its own lane PC, and reports how many lanes were set.
module enq_lane_compactor
  import decode_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH     = 2,
  parameter int unsigned INST_ADDR_WIDTH = 32
) (
  input  logic [FETCH_WIDTH-1:0]                enq_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]          enq_inst,
  input  logic [INST_ADDR_WIDTH-1:0]            enq_pc,
  output iq_entry_t [FETCH_WIDTH-1:0]           entries,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]      n_enq
);

  localparam int unsigned NEnqW = $clog2(FETCH_WIDTH + 1);

  iq_entry_t [FETCH_WIDTH-1:0] lane_entry;

  // PCs are attached per lane before packing so a gap never shifts a PC.
  always_comb begin
    for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
      lane_entry[i].inst = enq_inst[i];
      lane_entry[i].pc   = IQ_PC_WIDTH'(enq_pc + INST_ADDR_WIDTH'(PC_STEP * i));
    end
  end

  always_comb begin
    entries = '0;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
        if (enq_valid[i] &&
            popcount(32'(enq_valid & FETCH_WIDTH'((32'd1 << i) - 32'd1))) == k) begin
          entries[k] = lane_entry[i];
        end
      end
    end
  end

  assign n_enq = NEnqW'(popcount(32'(enq_valid)));

endmodule

// File: rtl/decode_inst_queue.sv
// Multi-lane circular instruction queue between fetch and decode/rename with
// first-word-fall-through head lanes, flush, and a sticky protocol error flag.
module decode_inst_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH     = 2,
  parameter int unsigned DEQ_WIDTH       = 2,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned INST_ADDR_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH-1:0]                 enq_valid,
  input  logic [FETCH_WIDTH-1:0][31:0]           enq_inst,
  input  logic [INST_ADDR_WIDTH-1:0]             enq_pc,
  output logic                                   enq_ready,
  output logic [DEQ_WIDTH-1:0]                   deq_valid,
  output logic [DEQ_WIDTH-1:0][31:0]             deq_inst,
  output logic [DEQ_WIDTH-1:0][INST_ADDR_WIDTH-1:0] deq_pc,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]         deq_accept_cnt,
  output logic [$clog2(DEPTH+1)-1:0]             count,
  output logic                                   err
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned NEnqW = $clog2(FETCH_WIDTH + 1);

  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             err_q, err_d;
  iq_entry_t        mem_q [DEPTH];

  iq_entry_t [FETCH_WIDTH-1:0] comp_entries;
  logic [NEnqW-1:0]            n_enq;
  logic [CntW-1:0]             n_enq_c, n_deq, accept_c;
  logic                        any_valid, enq_fire, enq_drop, deq_under;

  enq_lane_compactor #(
    .FETCH_WIDTH     (FETCH_WIDTH),
    .INST_ADDR_WIDTH (INST_ADDR_WIDTH)
  ) u_compactor (
    .enq_valid (enq_valid),
    .enq_inst  (enq_inst),
    .enq_pc    (enq_pc),
    .entries   (comp_entries),
    .n_enq     (n_enq)
  );

  // Ready looks only at the registered count so deq_accept_cnt stays off this path.
  assign enq_ready = (count_q <= CntW'(DEPTH - FETCH_WIDTH));

  always_comb begin
    any_valid = |enq_valid;
    accept_c  = CntW'(deq_accept_cnt);
    enq_fire  = !flush && enq_ready && any_valid;
    enq_drop  = !flush && !enq_ready && any_valid;
    deq_under = !flush && (accept_c > count_q);
    n_enq_c   = enq_fire ? CntW'(n_enq) : '0;
    n_deq     = flush ? '0 : (deq_under ? count_q : accept_c);
  end

  always_comb begin
    head_d  = head_q + PtrW'(n_deq);
    tail_d  = tail_q + PtrW'(n_enq_c);
    count_d = count_q + n_enq_c - n_deq;
    err_d   = err_q | enq_drop | deq_under;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (enq_fire) begin
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
          if (k < 32'(n_enq)) begin
            mem_q[tail_q + PtrW'(k)] <= comp_entries[k];
          end
        end
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < DEQ_WIDTH; j++) begin
      deq_valid[j] = (count_q > CntW'(j));
      deq_inst[j]  = mem_q[head_q + PtrW'(j)].inst;
      deq_pc[j]    = INST_ADDR_WIDTH'(mem_q[head_q + PtrW'(j)].pc);
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: tb/tb_decode_inst_queue.sv
// Directed bench for decode_inst_queue: a vector table for the basic flow plus
// hand-written sequences for wrap-around, underflow, flush and mid-fill reset.
module tb_decode_inst_queue;

  logic             clk = 1'b0;
  logic             reset, flush;
  logic [1:0]       enq_valid;
  logic [1:0][31:0] enq_inst;
  logic [31:0]      enq_pc;
  logic             enq_ready;
  logic [1:0]       deq_valid;
  logic [1:0][31:0] deq_inst;
  logic [1:0][31:0] deq_pc;
  logic [1:0]       deq_accept_cnt;
  logic [3:0]       count;
  logic             err;

  int n_pass   = 0;
  int n_checks = 0;

  decode_inst_queue #(
    .FETCH_WIDTH     (2),
    .DEQ_WIDTH       (2),
    .DEPTH           (8),
    .INST_ADDR_WIDTH (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .enq_valid      (enq_valid),
    .enq_inst       (enq_inst),
    .enq_pc         (enq_pc),
    .enq_ready      (enq_ready),
    .deq_valid      (deq_valid),
    .deq_inst       (deq_inst),
    .deq_pc         (deq_pc),
    .deq_accept_cnt (deq_accept_cnt),
    .count          (count),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic [1:0]  ev;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] pc;
    logic [1:0]  acc;
    logic [3:0]  cnt;
    logic        rdy;
    logic [1:0]  dv;
    logic        er;
    logic [31:0] ei0;
    logic [31:0] ei1;
    logic [31:0] ep0;
    logic [31:0] ep1;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic f, input logic [1:0] ev,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] pc, input logic [1:0] acc);
    reset          = r;
    flush          = f;
    enq_valid      = ev;
    enq_inst[0]    = i0;
    enq_inst[1]    = i1;
    enq_pc         = pc;
    deq_accept_cnt = acc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_q [$];
    logic [31:0] pc;
    logic [31:0] last_pc;

    vecs[0]  = '{1, 0, 2'b00, 32'h0,        32'h0,        32'h000, 2'd0,
                 4'd0, 1, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = vecs[0];
    vecs[2]  = '{0, 0, 2'b11, 32'hAAAA0001, 32'hBBBB0002, 32'h100, 2'd0,
                 4'd2, 1, 2'b11, 0, 32'hAAAA0001, 32'hBBBB0002, 32'h100, 32'h104};
    vecs[3]  = '{0, 0, 2'b00, 32'h0,        32'h0,        32'h000, 2'd2,
                 4'd0, 1, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{0, 0, 2'b10, 32'h0000DEAD, 32'hCCCC0003, 32'h200, 2'd0,
                 4'd1, 1, 2'b01, 0, 32'hCCCC0003, 32'h0, 32'h204, 32'h0};
    vecs[5]  = '{0, 0, 2'b00, 32'h0,        32'h0,        32'h000, 2'd1,
                 4'd0, 1, 2'b00, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[6]  = '{0, 0, 2'b11, 32'h11110000, 32'h11110001, 32'h300, 2'd0,
                 4'd2, 1, 2'b11, 0, 32'h11110000, 32'h11110001, 32'h300, 32'h304};
    vecs[7]  = '{0, 0, 2'b11, 32'h11110002, 32'h11110003, 32'h308, 2'd0,
                 4'd4, 1, 2'b11, 0, 32'h11110000, 32'h11110001, 32'h300, 32'h304};
    vecs[8]  = '{0, 0, 2'b11, 32'h11110004, 32'h11110005, 32'h310, 2'd0,
                 4'd6, 1, 2'b11, 0, 32'h11110000, 32'h11110001, 32'h300, 32'h304};
    vecs[9]  = '{0, 0, 2'b11, 32'h11110006, 32'h11110007, 32'h318, 2'd0,
                 4'd8, 0, 2'b11, 0, 32'h11110000, 32'h11110001, 32'h300, 32'h304};
    vecs[10] = '{0, 0, 2'b11, 32'h11110008, 32'h11110009, 32'h320, 2'd0,
                 4'd8, 0, 2'b11, 1, 32'h11110000, 32'h11110001, 32'h300, 32'h304};
    vecs[11] = '{0, 0, 2'b00, 32'h0,        32'h0,        32'h000, 2'd1,
                 4'd7, 0, 2'b11, 1, 32'h11110001, 32'h11110002, 32'h304, 32'h308};

    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].rst, vecs[v].fl, vecs[v].ev, vecs[v].i0, vecs[v].i1, vecs[v].pc,
            vecs[v].acc);
      step();
      check($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].cnt));
      check($sformatf("vec%0d_ready", v), 32'(enq_ready), 32'(vecs[v].rdy));
      check($sformatf("vec%0d_deq_valid", v), 32'(deq_valid), 32'(vecs[v].dv));
      check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].er));
      if (vecs[v].dv[0]) begin
        check($sformatf("vec%0d_inst0", v), deq_inst[0], vecs[v].ei0);
        check($sformatf("vec%0d_pc0", v), deq_pc[0], vecs[v].ep0);
      end
      if (vecs[v].dv[1]) begin
        check($sformatf("vec%0d_inst1", v), deq_inst[1], vecs[v].ei1);
        check($sformatf("vec%0d_pc1", v), deq_pc[1], vecs[v].ep1);
      end
    end

    // Steady enqueue/dequeue at count 6 so head and tail both cross 7 -> 0.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      pc = 32'h1000 + 32'(8 * n);
      drive(1'b0, 1'b0, 2'b11, 32'hC0DE0000 + 32'(2 * n), 32'hC0DE0001 + 32'(2 * n),
            pc, 2'd0);
      exp_q.push_back(pc);
      exp_q.push_back(pc + 32'h4);
      step();
    end
    check("wrap_fill_count", 32'(count), 32'd6);
    last_pc = 32'h0;
    for (int c = 0; c < 9; c++) begin
      pc = 32'h1000 + 32'(8 * (3 + c));
      drive(1'b0, 1'b0, 2'b11, 32'hD0000000 + 32'(c), 32'hD1000000 + 32'(c), pc, 2'd2);
      #1;
      check($sformatf("wrap%0d_pc0", c), deq_pc[0], exp_q[0]);
      check($sformatf("wrap%0d_pc1", c), deq_pc[1], exp_q[1]);
      check($sformatf("wrap%0d_order", c), 32'(deq_pc[0] > last_pc), 32'd1);
      last_pc = deq_pc[1];
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      exp_q.push_back(pc);
      exp_q.push_back(pc + 32'h4);
      step();
      check($sformatf("wrap%0d_count", c), 32'(count), 32'd6);
    end
    check("wrap_err", 32'(err), 32'd0);

    // Accepting more than is held clamps to count and flags err.
    do_reset();
    drive(1'b0, 1'b0, 2'b01, 32'hE0000001, 32'h0, 32'h600, 2'd0);
    step();
    check("under_fill_count", 32'(count), 32'd1);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd2);
    step();
    check("under_count", 32'(count), 32'd0);
    check("under_deq_valid", 32'(deq_valid), 32'd0);
    check("under_err", 32'(err), 32'd1);

    // Flush with concurrent enqueue/over-accept: everything dropped, err held at 1.
    drive(1'b0, 1'b0, 2'b11, 32'hF0000000, 32'hF0000001, 32'h700, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'b11, 32'hF0000002, 32'hF0000003, 32'h708, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'b01, 32'hF0000004, 32'h0, 32'h710, 2'd0);
    step();
    check("flush_pre_count", 32'(count), 32'd5);
    drive(1'b0, 1'b1, 2'b11, 32'hF0000005, 32'hF0000006, 32'h718, 2'd2);
    step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_deq_valid", 32'(deq_valid), 32'd0);
    check("flush_ready", 32'(enq_ready), 32'd1);
    check("flush_err_held", 32'(err), 32'd1);

    // Flush with an over-accept while empty must not raise err.
    do_reset();
    drive(1'b0, 1'b1, 2'b11, 32'h1, 32'h2, 32'h800, 2'd2);
    step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
    check("flush_noerr_count", 32'(count), 32'd0);
    check("flush_noerr_err", 32'(err), 32'd0);

    // Reset mid-fill with err set returns every output to its reset value.
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd1);
    step();
    drive(1'b0, 1'b0, 2'b11, 32'h9000000A, 32'h9000000B, 32'h500, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'b01, 32'h9000000C, 32'h0, 32'h508, 2'd0);
    step();
    check("midfill_count", 32'(count), 32'd3);
    check("midfill_err", 32'(err), 32'd1);
    check("midfill_inst0", deq_inst[0], 32'h9000000A);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
    step();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(enq_ready), 32'd1);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_inst0", deq_inst[0], 32'h0);
    check("rst_inst1", deq_inst[1], 32'h0);
    check("rst_pc0", deq_pc[0], 32'h0);
    check("rst_pc1", deq_pc[1], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
